// File: rtl/bsg_thermometer_credit_counter_pkg.sv
// Shared types for the thermometer credit counter.
package bsg_thermometer_credit_counter_pkg;

  // Sticky error flags, cleared only by reset.
  typedef struct packed {
    logic ovf;   // a return pushed the count past capacity
    logic unf;   // a take arrived with no credit held
  } err_flags_t;

endpackage

// File: rtl/bsg_thermometer_credit_counter_count.sv
// Population count of a thermometer code; purely combinational.
module bsg_thermometer_count #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0]           therm,
  output logic [$clog2(width_p+1)-1:0] count
);

  localparam int cnt_w = $clog2(width_p + 1);

  // Sum the set bits; the input is 0*1* so this equals the position of the top one plus one.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch or loop, otherwise a latch is inferred.
    count = '0;
    for (int i = 0; i < width_p; i++) begin
      count = count + cnt_w'(therm[i]);
    end
  end

endmodule

// File: rtl/bsg_thermometer_credit_counter.sv
// Credit counter kept as a thermometer code: one take and up to max_step_p returns per cycle.
module bsg_thermometer_credit_counter
  import bsg_thermometer_credit_counter_pkg::*;
#(
  // Capacity; sized by the instantiating design.
  parameter int width_p        = 8,
  parameter int max_step_p     = 1,
  parameter int init_credits_p = width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [$clog2(max_step_p+1)-1:0] ret_cnt_i,
  input  logic                            take_i,
  output logic [width_p-1:0]              therm_o,
  output logic [$clog2(width_p+1)-1:0]    count_o,
  output logic                            avail_o,
  output logic                            full_o,
  output logic                            overflow_o,
  output logic                            underflow_o
);

  localparam logic [width_p-1:0] all_ones   = '1;
  localparam logic [width_p-1:0] init_therm = ~(all_ones << init_credits_p);

  if (max_step_p < 1 || max_step_p > width_p) begin : g_bad_step
    $error("max_step_p must be in 1..width_p");
  end
  if (init_credits_p < 0 || init_credits_p > width_p) begin : g_bad_init
    $error("init_credits_p must be in 0..width_p");
  end

  logic [width_p-1:0] therm_r;
  logic [width_p-1:0] therm_mid;
  logic [width_p-1:0] therm_n;
  logic               take_ok;
  logic               ovf_n;
  err_flags_t         err_r;

  // Take step: a legal take shifts one credit out of the bottom of the code.
  always_comb begin
    take_ok   = take_i & therm_r[0];
    therm_mid = take_ok ? (therm_r >> 1) : therm_r;
  end

  // Return step: one mux leg per legal shift amount; ones fill in from the bottom.
  // A one in bit width_p-k of the intermediate code is about to be shifted out, i.e. overflow.
  always_comb begin
    therm_n = therm_mid;
    ovf_n   = 1'b0;
    for (int k = 1; k <= max_step_p; k++) begin
      if (int'(ret_cnt_i) == k) begin
        therm_n = (therm_mid << k) | ~(all_ones << k);
        ovf_n   = therm_mid[width_p-k];
      end
    end
  end

  // Credit register and set-only sticky flags; reset wins over any traffic that cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) begin
      therm_r <= init_therm;
      err_r   <= '0;
    end else begin
      therm_r <= therm_n;
      if (ovf_n)                err_r.ovf <= 1'b1;
      if (take_i && !therm_r[0]) err_r.unf <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Returning more than max_step_p credits in one cycle is a protocol error upstream.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (int'(ret_cnt_i) <= max_step_p)
        else $error("ret_cnt_i=%0d exceeds max_step_p=%0d", ret_cnt_i, max_step_p);
    end
  end
`endif

  bsg_thermometer_count #(.width_p(width_p)) u_count (
    .therm (therm_r),
    .count (count_o)
  );

  assign therm_o     = therm_r;
  assign avail_o     = therm_r[0];
  assign full_o      = therm_r[width_p-1];
  assign overflow_o  = err_r.ovf;
  assign underflow_o = err_r.unf;

endmodule

// File: tb/tb_bsg_thermometer_credit_counter.sv
// Directed and constrained-random checks of bsg_thermometer_credit_counter in three configurations.
module tb_bsg_thermometer_credit_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // A: width 8, step 3, starts full.
  logic       a_take;
  logic [1:0] a_ret;
  logic [7:0] a_therm;
  logic [3:0] a_count;
  logic       a_avail, a_full, a_ovf, a_unf;

  // B: width 8, step 3, starts empty.
  logic       b_take;
  logic [1:0] b_ret;
  logic [7:0] b_therm;
  logic [3:0] b_count;
  logic       b_avail, b_full, b_ovf, b_unf;

  // C: width 1, step 1, starts full.
  logic       c_take;
  logic       c_ret;
  logic       c_therm;
  logic       c_count;
  logic       c_avail, c_full, c_ovf, c_unf;

  bsg_thermometer_credit_counter #(.width_p(8), .max_step_p(3), .init_credits_p(8)) dut_a (
    .clk_i(clk), .reset_i(reset), .ret_cnt_i(a_ret), .take_i(a_take),
    .therm_o(a_therm), .count_o(a_count), .avail_o(a_avail), .full_o(a_full),
    .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  bsg_thermometer_credit_counter #(.width_p(8), .max_step_p(3), .init_credits_p(0)) dut_b (
    .clk_i(clk), .reset_i(reset), .ret_cnt_i(b_ret), .take_i(b_take),
    .therm_o(b_therm), .count_o(b_count), .avail_o(b_avail), .full_o(b_full),
    .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  bsg_thermometer_credit_counter #(.width_p(1), .max_step_p(1), .init_credits_p(1)) dut_c (
    .clk_i(clk), .reset_i(reset), .ret_cnt_i(c_ret), .take_i(c_take),
    .therm_o(c_therm), .count_o(c_count), .avail_o(c_avail), .full_o(c_full),
    .overflow_o(c_ovf), .underflow_o(c_unf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_take = 1'b0; a_ret = 2'd0;
    b_take = 1'b0; b_ret = 2'd0;
    c_take = 1'b0; c_ret = 1'b0;
  endtask

  initial begin
    int m;
    int tk;
    int rt;
    int max_rt;

    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset values for all three configurations.
    check("a_rst_therm", a_therm, 8'hFF);
    check("a_rst_count", a_count, 8);
    check("a_rst_full",  a_full,  1);
    check("a_rst_avail", a_avail, 1);
    check("a_rst_ovf",   a_ovf,   0);
    check("a_rst_unf",   a_unf,   0);
    check("b_rst_therm", b_therm, 0);
    check("b_rst_count", b_count, 0);
    check("b_rst_avail", b_avail, 0);
    check("b_rst_full",  b_full,  0);
    check("c_rst_count", c_count, 1);
    check("c_rst_full",  c_full,  1);

    // A: drain a full counter with back-to-back takes.
    a_take = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("a_drain_count_%0d", i), a_count, 7 - i);
    end
    a_take = 1'b0;
    check("a_drain_avail", a_avail, 0);
    check("a_drain_therm", a_therm, 0);
    check("a_drain_unf",   a_unf,   0);

    // A: take at empty with a return: return applies, take ignored, underflow set.
    a_take = 1'b1; a_ret = 2'd1;
    tick();
    a_take = 1'b0; a_ret = 2'd0;
    check("a_unf_count", a_count, 1);
    check("a_unf_therm", a_therm, 8'h01);
    check("a_unf_flag",  a_unf,   1);

    // A: climb to 7, then overflow by returning 3.
    a_ret = 2'd3; tick();
    check("a_climb4", a_count, 4);
    tick();
    check("a_climb7",     a_count, 7);
    check("a_climb7_ovf", a_ovf,   0);
    tick();
    a_ret = 2'd0;
    check("a_ovf_count", a_count, 8);
    check("a_ovf_therm", a_therm, 8'hFF);
    check("a_ovf_flag",  a_ovf,   1);
    a_take = 1'b1; tick(); a_take = 1'b0;
    check("a_post_ovf_count", a_count, 7);
    check("a_ovf_sticky",     a_ovf,   1);
    check("a_unf_sticky",     a_unf,   1);

    // A: reset with traffic in flight; traffic is discarded and flags clear.
    reset = 1'b1; a_take = 1'b1; a_ret = 2'd2;
    tick();
    reset = 1'b0; a_take = 1'b0; a_ret = 2'd0;
    check("a_rerst_count", a_count, 8);
    check("a_rerst_ovf",   a_ovf,   0);
    check("a_rerst_unf",   a_unf,   0);
    // The reset also re-initialised B and C, which stay at their init values.

    // B: return 3 from empty, then simultaneous take + return 2.
    b_ret = 2'd3; tick();
    check("b_ret3_therm", b_therm, 8'h07);
    check("b_ret3_count", b_count, 3);
    b_ret = 2'd2; b_take = 1'b1; tick();
    b_ret = 2'd0; b_take = 1'b0;
    check("b_mix_count", b_count, 4);
    check("b_mix_therm", b_therm, 8'h0F);
    check("b_mix_ovf",   b_ovf,   0);
    check("b_mix_unf",   b_unf,   0);

    // C: single-credit counter.
    c_take = 1'b1; tick(); c_take = 1'b0;
    check("c_take_count", c_count, 0);
    check("c_take_avail", c_avail, 0);
    check("c_take_full",  c_full,  0);
    c_ret = 1'b1; tick(); c_ret = 1'b0;
    check("c_ret_count", c_count, 1);
    c_take = 1'b1; c_ret = 1'b1; tick(); c_take = 1'b0; c_ret = 1'b0;
    check("c_both_count", c_count, 1);
    check("c_both_ovf",   c_ovf,   0);
    c_ret = 1'b1; tick(); c_ret = 1'b0;
    check("c_full_ret_count", c_count, 1);
    check("c_full_ret_ovf",   c_ovf,   1);
    c_take = 1'b1; tick(); c_take = 1'b0;
    check("c_after_count", c_count, 0);
    check("c_ovf_sticky",  c_ovf,   1);
    check("c_unf",         c_unf,   0);

    // A: legal random traffic against a binary model, with one reset mid-run.
    m = 8;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        reset  = 1'b1;
        a_take = 1'($urandom_range(0, 1));
        a_ret  = 2'($urandom_range(0, 3));
        m = 8;
      end else begin
        tk = (m > 0) ? int'($urandom_range(0, 1)) : 0;
        max_rt = 8 - m + tk;
        if (max_rt > 3) max_rt = 3;
        rt = int'($urandom_range(0, max_rt));
        a_take = 1'(tk);
        a_ret  = 2'(rt);
        m = m - tk + rt;
      end
      tick();
      reset = 1'b0;
      check("rnd_count", a_count, m);
      check("rnd_therm", a_therm, (1 << m) - 1);
      check("rnd_avail", a_avail, (m > 0) ? 1 : 0);
      check("rnd_full",  a_full,  (m == 8) ? 1 : 0);
      check("rnd_ovf",   a_ovf,   0);
      check("rnd_unf",   a_unf,   0);
    end
    idle_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
